// File: rtl/bus_pkg.sv
// Shared constants and helpers for the datapath bus arbiter.
package bus_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;
  localparam int unsigned MAX_SRC   = 64;

  // Index width that stays at least one bit wide for the two-source case.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : int'($clog2(n));
  endfunction

  // True when more than one request bit is set.
  function automatic logic multi_hot(input logic [MAX_SRC-1:0] v);
    return (v & (v - MAX_SRC'(1))) != '0;
  endfunction

endpackage

// File: rtl/bus_arb_if.sv
// Source request / shared bus bundle between datapath drivers and the arbiter.
interface bus_arb_if
  import bus_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 27,
  parameter int unsigned CNTW  = 16
);

  localparam int unsigned IW = idx_w(NSRC);

  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_out;
  logic                  conflict_clr;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [IW-1:0]         sel_idx;
  logic                  conflict;
  logic                  conflict_sticky;
  logic [CNTW-1:0]       xfer_count;

  modport master (
    output src_data, src_out, conflict_clr,
    input  bus_out, bus_valid, sel_idx, conflict, conflict_sticky, xfer_count
  );

  modport slave (
    input  src_data, src_out, conflict_clr,
    output bus_out, bus_valid, sel_idx, conflict, conflict_sticky, xfer_count
  );

endinterface

// File: rtl/bus_arb_rr_pick.sv
// Rotating-start priority encoder: first asserted request at or after start, wrapping modulo NSRC.
module rr_pick #(
  parameter int unsigned NSRC = 27,
  parameter int unsigned IW   = 5
) (
  input  logic [NSRC-1:0] req,
  input  logic [IW-1:0]   start,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  logic [NSRC-1:0] rot;
  logic [IW-1:0]   off;
  logic [IW:0]     sum;

  always_comb begin
    rot = NSRC'({req, req} >> start);
    off = '0;
    // Descending scan so the lowest offset from start is the last write.
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, start} + (IW+1)'(off);
    if (sum >= (IW+1)'(NSRC)) sum = sum - (IW+1)'(NSRC);
    grant_idx = sum[IW-1:0];
    any       = |req;
  end

endmodule

// File: rtl/bus_arb.sv
// Registered shared-bus multiplexer with fixed-priority or round-robin arbitration and conflict flagging.
module bus_arb
  import bus_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 27,
  parameter int unsigned MODE  = ARB_FIXED,
  parameter int unsigned CNTW  = 16
) (
  input  logic      clk,
  input  logic      clr,
  bus_arb_if.slave  bus
);

  localparam int unsigned IW = idx_w(NSRC);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] start;
  logic [IW-1:0] win;
  logic          any;
  logic          multi;

  assign start = (MODE == ARB_RR) ? rr_ptr : '0;
  assign multi = multi_hot(MAX_SRC'(bus.src_out));

  rr_pick #(.NSRC(NSRC), .IW(IW)) u_pick (
    .req       (bus.src_out),
    .start     (start),
    .grant_idx (win),
    .any       (any)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      bus.bus_out         <= '0;
      bus.bus_valid       <= 1'b0;
      bus.sel_idx         <= '0;
      bus.conflict        <= 1'b0;
      bus.conflict_sticky <= 1'b0;
      bus.xfer_count      <= '0;
      rr_ptr              <= '0;
    end else begin
      bus.bus_valid <= any;
      bus.conflict  <= multi;
      // Bus and select hold their last value on idle cycles.
      if (any) begin
        bus.bus_out <= bus.src_data[32'(win) * WIDTH +: WIDTH];
        bus.sel_idx <= win;
        if (MODE == ARB_RR) rr_ptr <= (win == IW'(NSRC - 1)) ? '0 : win + IW'(1);
      end
      // A fresh conflict outranks a simultaneous clear.
      if (multi)                 bus.conflict_sticky <= 1'b1;
      else if (bus.conflict_clr) bus.conflict_sticky <= 1'b0;
      if (any && (bus.xfer_count != '1)) bus.xfer_count <= bus.xfer_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_bus_arb.sv
// Self-checking bench for bus_arb: fixed-priority, round-robin and odd-NSRC instances with a scoreboard queue.
module tb_bus_arb;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  bus_arb_if #(.WIDTH(8), .NSRC(4), .CNTW(4))  ia ();
  bus_arb_if #(.WIDTH(8), .NSRC(4), .CNTW(16)) ib ();
  bus_arb_if #(.WIDTH(8), .NSRC(5), .CNTW(16)) ic ();

  bus_arb #(.WIDTH(8), .NSRC(4), .MODE(ARB_FIXED), .CNTW(4))  dut_a (.clk(clk), .clr(clr), .bus(ia.slave));
  bus_arb #(.WIDTH(8), .NSRC(4), .MODE(ARB_RR),    .CNTW(16)) dut_b (.clk(clk), .clr(clr), .bus(ib.slave));
  bus_arb #(.WIDTH(8), .NSRC(5), .MODE(ARB_RR),    .CNTW(16)) dut_c (.clk(clk), .clr(clr), .bus(ic.slave));

  typedef struct {
    logic [4:0]  so;
    logic [39:0] sd;
    logic        cc;
    logic [7:0]  eb;
    logic        ev;
    logic [2:0]  es;
    logic        ec;
    logic        est;
  } vec_t;

  typedef struct {
    int          dut;
    logic [7:0]  eb;
    logic        ev;
    logic [2:0]  es;
    logic        ec;
    logic        est;
    logic [15:0] ecnt;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cnt[3];
  int unsigned cmax[3] = '{15, 65535, 65535};
  int          n_vec = 0;
  int          n_bad = 0;

  vec_t va[10];
  vec_t vb[11];

  task automatic chk(string tag, string f, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h, expected %0h", tag, f, act, exp);
    end
  endtask

  task automatic idle_all();
    ia.src_out = '0; ia.src_data = '0; ia.conflict_clr = 1'b0;
    ib.src_out = '0; ib.src_data = '0; ib.conflict_clr = 1'b0;
    ic.src_out = '0; ic.src_data = '0; ic.conflict_clr = 1'b0;
  endtask

  task automatic set_in(int d, logic [4:0] so, logic [39:0] sd, logic cc);
    case (d)
      0: begin ia.src_out = so[3:0]; ia.src_data = sd[31:0]; ia.conflict_clr = cc; end
      1: begin ib.src_out = so[3:0]; ib.src_data = sd[31:0]; ib.conflict_clr = cc; end
      default: begin ic.src_out = so; ic.src_data = sd; ic.conflict_clr = cc; end
    endcase
  endtask

  // Push the expected post-edge state; transfer count comes from a saturating model.
  task automatic expect_out(int d, logic [7:0] eb, logic ev, logic [2:0] es, logic ec, logic est, string tag);
    exp_t e;
    if (clr) cnt[d] = 0;
    else if (ev && cnt[d] < cmax[d]) cnt[d]++;
    e.dut = d; e.eb = eb; e.ev = ev; e.es = es; e.ec = ec; e.est = est;
    e.ecnt = 16'(cnt[d]); e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    logic [7:0]  ab;
    logic        av, ac, ast;
    logic [2:0]  as;
    logic [15:0] an;
    @(posedge clk);
    #1;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      case (e.dut)
        0: begin ab = ia.bus_out; av = ia.bus_valid; as = 3'(ia.sel_idx); ac = ia.conflict;
                 ast = ia.conflict_sticky; an = 16'(ia.xfer_count); end
        1: begin ab = ib.bus_out; av = ib.bus_valid; as = 3'(ib.sel_idx); ac = ib.conflict;
                 ast = ib.conflict_sticky; an = 16'(ib.xfer_count); end
        default: begin ab = ic.bus_out; av = ic.bus_valid; as = ic.sel_idx; ac = ic.conflict;
                 ast = ic.conflict_sticky; an = 16'(ic.xfer_count); end
      endcase
      chk(e.tag, "bus_out",         16'(ab),  16'(e.eb));
      chk(e.tag, "bus_valid",       16'(av),  16'(e.ev));
      chk(e.tag, "sel_idx",         16'(as),  16'(e.es));
      chk(e.tag, "conflict",        16'(ac),  16'(e.ec));
      chk(e.tag, "conflict_sticky", 16'(ast), 16'(e.est));
      chk(e.tag, "xfer_count",      an,       e.ecnt);
    end
    @(negedge clk);
  endtask

  task automatic step(int d, logic [4:0] so, logic [39:0] sd, logic cc,
                      logic [7:0] eb, logic ev, logic [2:0] es, logic ec, logic est, string tag);
    idle_all();
    set_in(d, so, sd, cc);
    expect_out(d, eb, ev, es, ec, est, tag);
    tick();
  endtask

  initial begin
    // Fixed priority, NSRC=4: src3=11 src2=A5 src1=22 src0=33
    va[0] = '{5'b00100, 40'h0011A52233, 1'b0, 8'hA5, 1'b1, 3'd2, 1'b0, 1'b0};
    va[1] = '{5'b00000, 40'h0011A52233, 1'b0, 8'hA5, 1'b0, 3'd2, 1'b0, 1'b0};
    va[2] = '{5'b01010, 40'h0011A52233, 1'b0, 8'h22, 1'b1, 3'd1, 1'b1, 1'b1};
    va[3] = '{5'b00000, 40'h0011A52233, 1'b0, 8'h22, 1'b0, 3'd1, 1'b0, 1'b1};
    va[4] = '{5'b00000, 40'h0011A52233, 1'b1, 8'h22, 1'b0, 3'd1, 1'b0, 1'b0};
    va[5] = '{5'b00011, 40'h0011A52233, 1'b1, 8'h33, 1'b1, 3'd0, 1'b1, 1'b1};
    va[6] = '{5'b00000, 40'h0011A52233, 1'b0, 8'h33, 1'b0, 3'd0, 1'b0, 1'b1};
    va[7] = '{5'b01000, 40'h00C3000000, 1'b0, 8'hC3, 1'b1, 3'd3, 1'b0, 1'b1};
    va[8] = '{5'b01111, 40'h00C3000000, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b1};
    va[9] = '{5'b00000, 40'h00C3000000, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
    // Round robin, NSRC=4: src i = (i+1)*11
    vb[0]  = '{5'b01111, 40'h0044332211, 1'b0, 8'h11, 1'b1, 3'd0, 1'b1, 1'b1};
    vb[1]  = '{5'b01111, 40'h0044332211, 1'b0, 8'h22, 1'b1, 3'd1, 1'b1, 1'b1};
    vb[2]  = '{5'b01111, 40'h0044332211, 1'b0, 8'h33, 1'b1, 3'd2, 1'b1, 1'b1};
    vb[3]  = '{5'b01111, 40'h0044332211, 1'b0, 8'h44, 1'b1, 3'd3, 1'b1, 1'b1};
    vb[4]  = '{5'b01111, 40'h0044332211, 1'b0, 8'h11, 1'b1, 3'd0, 1'b1, 1'b1};
    vb[5]  = '{5'b01111, 40'h0044332211, 1'b0, 8'h22, 1'b1, 3'd1, 1'b1, 1'b1};
    vb[6]  = '{5'b01001, 40'h0044332211, 1'b0, 8'h44, 1'b1, 3'd3, 1'b1, 1'b1};
    vb[7]  = '{5'b01001, 40'h0044332211, 1'b0, 8'h11, 1'b1, 3'd0, 1'b1, 1'b1};
    vb[8]  = '{5'b00000, 40'h0044332211, 1'b0, 8'h11, 1'b0, 3'd0, 1'b0, 1'b1};
    vb[9]  = '{5'b00100, 40'h0044332211, 1'b0, 8'h33, 1'b1, 3'd2, 1'b0, 1'b1};
    vb[10] = '{5'b00000, 40'h0044332211, 1'b1, 8'h33, 1'b0, 3'd2, 1'b0, 1'b0};

    clr = 1'b1;
    idle_all();

    // Reset held with every source requesting: everything stays zero.
    for (int r = 0; r < 3; r++) begin
      idle_all();
      for (int d = 0; d < 3; d++) begin
        set_in(d, 5'b11111, '1, 1'b0);
        expect_out(d, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, $sformatf("rst%0d_d%0d", r, d));
      end
      tick();
    end
    clr = 1'b0;

    for (int i = 0; i < 10; i++)
      step(0, va[i].so, va[i].sd, va[i].cc, va[i].eb, va[i].ev, va[i].es, va[i].ec, va[i].est,
           $sformatf("fix%0d", i));

    for (int i = 0; i < 11; i++)
      step(1, vb[i].so, vb[i].sd, vb[i].cc, vb[i].eb, vb[i].ev, vb[i].es, vb[i].ec, vb[i].est,
           $sformatf("rr%0d", i));

    // NSRC=5 round robin: 0 and 4 alternate, pointer wraps modulo 5.
    for (int i = 0; i < 6; i++) begin
      step(2, 5'b10001, 40'hF00000B15A, 1'b0, (i % 2 == 0) ? 8'h5A : 8'hF0, 1'b1,
           (i % 2 == 0) ? 3'd0 : 3'd4, 1'b1, 1'b1, $sformatf("odd%0d", i));
      chk($sformatf("odd%0d", i), "sel_range", 16'(ic.sel_idx < 3'd5), 16'd1);
    end
    step(2, 5'b00010, 40'hF00000B15A, 1'b0, 8'hB1, 1'b1, 3'd1, 1'b0, 1'b1, "odd_wrap1");
    step(2, 5'b00011, 40'hF00000B15A, 1'b0, 8'h5A, 1'b1, 3'd0, 1'b1, 1'b1, "odd_wrap2");

    // Saturation of the 4-bit counter, then reset mid-stream.
    for (int i = 0; i < 20; i++)
      step(0, 5'b00001, 40'(i + 1), 1'b0, 8'(i + 1), 1'b1, 3'd0, 1'b0, 1'b0, $sformatf("sat%0d", i));
    clr = 1'b1;
    step(0, 5'b00001, 40'h0000000099, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, "midrst");
    clr = 1'b0;
    step(0, 5'b00010, 40'h0000007700, 1'b0, 8'h77, 1'b1, 3'd1, 1'b0, 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
